// File: rtl/rrp_mult_sched.sv
// Round-robin scheduler that lets two requesters share one fixed-latency pipelined multiplier.
// In-flight ops are tracked with a tag pipeline, and results return in order through a credit-protected FIFO.
module rrp_mult_sched #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned RADIX      = 4,
  parameter int unsigned LAT        = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  localparam int unsigned D  = $clog2(RADIX) + 1,
  localparam int unsigned OW = D * WIDTH,
  localparam int unsigned PW = D * (2 * WIDTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [OW-1:0] a_x,
  input  logic [OW-1:0] a_y,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [OW-1:0] b_x,
  input  logic [OW-1:0] b_y,
  output logic [OW-1:0] mul_x,
  output logic [OW-1:0] mul_y,
  input  logic [PW-1:0] mul_p,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [PW-1:0] r_p,
  output logic          r_id,
  output logic          busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(LAT + 2);
  localparam int unsigned SW = $clog2(FIFO_DEPTH + LAT + 2) + 1;

  logic          ptr;
  logic [LAT:0]  tag_v;
  logic [LAT:0]  tag_id;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] mem_p [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_id;

  logic [IW-1:0] inflight;
  logic          issue_ok;
  logic          grant_a;
  logic          grant_b;
  logic          push;
  logic          pop;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Credit and arbitration; both credit terms are registered.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= LAT; i++) begin
      inflight = inflight + IW'(tag_v[i]);
    end
    issue_ok = (SW'(inflight) + SW'(count)) < SW'(FIFO_DEPTH);
    a_ready  = issue_ok & (~ptr | ~b_valid);
    b_ready  = issue_ok & (ptr | ~a_valid);
    grant_a  = a_valid & a_ready;
    grant_b  = b_valid & b_ready;
    push     = tag_v[LAT];
    r_valid  = (count != '0);
    pop      = r_valid & r_ready;
    r_p      = r_valid ? mem_p[rd_ptr] : '0;
    r_id     = r_valid & mem_id[rd_ptr];
    busy     = (|tag_v) | r_valid;
  end

  // Issue stage, priority pointer and tag pipeline.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr    <= 1'b0;
      mul_x  <= '0;
      mul_y  <= '0;
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      if (grant_a) begin
        mul_x <= a_x;
        mul_y <= a_y;
        ptr   <= 1'b1;
      end else if (grant_b) begin
        mul_x <= b_x;
        mul_y <= b_y;
        ptr   <= 1'b0;
      end else begin
        mul_x <= '0;
        mul_y <= '0;
      end
      tag_v  <= {tag_v[LAT-1:0], grant_a | grant_b};
      tag_id <= {tag_id[LAT-1:0], grant_b};
    end
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_p[wr_ptr]  <= mul_p;
      mem_id[wr_ptr] <= tag_id[LAT];
    end
  end

endmodule

// File: tb/tb_rrp_mult_sched.sv
// Bench for rrp_mult_sched: a two-stage multiplier model plus a queue-based
// reference model of credit, arbitration and in-order result delivery.
module tb_rrp_mult_sched;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned RADIX = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned D     = $clog2(RADIX) + 1;
  localparam int unsigned OW    = D * WIDTH;
  localparam int unsigned PW    = D * (2 * WIDTH + 1);

  logic          clock, reset;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [OW-1:0] a_x, a_y, b_x, b_y, mul_x, mul_y;
  logic [PW-1:0] mul_p, r_p;
  logic          r_valid, r_ready, r_id, busy;

  rrp_mult_sched #(.WIDTH(WIDTH), .RADIX(RADIX), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
    .r_valid(r_valid), .r_ready(r_ready), .r_p(r_p), .r_id(r_id), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Multiplier model: product appears LAT=2 edges after the operands.
  logic [PW-1:0] p1, p2;
  always @(posedge clock) begin
    p1 <= PW'(mul_x) * PW'(mul_y);
    p2 <= p1;
  end
  assign mul_p = p2;

  typedef struct {
    logic          id;
    logic [PW-1:0] p;
    int            avail;
  } ent_t;

  ent_t          q[$];
  int            now, acc, popped, nchk, nfail, hs_a;
  logic          mptr;
  logic [OW-1:0] exp_mx, exp_my;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle against the model, then advance the model across the next edge.
  task automatic cycle();
    logic ok, ea, eb, ev, eid;
    logic [PW-1:0] ep;
    @(negedge clock);
    ok  = (acc - popped) < int'(DEPTH);
    ea  = ok && (!mptr || !b_valid);
    eb  = ok && (mptr || !a_valid);
    ev  = 1'b0;
    ep  = '0;
    eid = 1'b0;
    if (q.size() > 0) begin
      if (q[0].avail <= now) begin
        ev  = 1'b1;
        ep  = q[0].p;
        eid = q[0].id;
      end
    end
    chk("a_ready", 64'(a_ready), 64'(ea));
    chk("b_ready", 64'(b_ready), 64'(eb));
    chk("r_valid", 64'(r_valid), 64'(ev));
    chk("r_p", 64'(r_p), 64'(ep));
    chk("r_id", 64'(r_id), 64'(eid));
    chk("busy", 64'(busy), 64'(acc != popped));
    chk("mul_x", 64'(mul_x), 64'(exp_mx));
    chk("mul_y", 64'(mul_y), 64'(exp_my));
    if (a_valid && a_ready) hs_a++;
    if (ev && r_ready) begin
      void'(q.pop_front());
      popped++;
    end
    if (a_valid && ea) begin
      q.push_back('{id: 1'b0, p: PW'(a_x) * PW'(a_y), avail: now + LAT + 2});
      acc++; mptr = 1'b1; exp_mx = a_x; exp_my = a_y;
    end else if (b_valid && eb) begin
      q.push_back('{id: 1'b1, p: PW'(b_x) * PW'(b_y), avail: now + LAT + 2});
      acc++; mptr = 1'b0; exp_mx = b_x; exp_my = b_y;
    end else begin
      exp_mx = '0; exp_my = '0;
    end
    @(posedge clock);
    now++;
    #1;
  endtask

  task automatic rand_ops();
    a_x = OW'($urandom); a_y = OW'($urandom);
    b_x = OW'($urandom); b_y = OW'($urandom);
  endtask

  task automatic drain();
    a_valid = 1'b0; b_valid = 1'b0; r_ready = 1'b1;
    for (int c = 0; c < 60 && acc != popped; c++) cycle();
    chk("drained", 64'(acc - popped), 64'(0));
  endtask

  task automatic model_reset();
    q.delete();
    acc = 0; popped = 0; mptr = 1'b0; exp_mx = '0; exp_my = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int start;
    nchk = 0; nfail = 0; now = 0; hs_a = 0;
    model_reset();
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; r_ready = 1'b0;
    a_x = '0; a_y = '0; b_x = '0; b_y = '0;
    #12;
    chk("rst_r_valid", 64'(r_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mul_x", 64'(mul_x), 64'(0));
    chk("rst_r_p", 64'(r_p), 64'(0));
    chk("rst_r_id", 64'(r_id), 64'(0));
    @(posedge clock); #1;
    reset = 1'b0;

    // Single op from A: 3*5.
    r_ready = 1'b1; a_valid = 1'b1; a_x = OW'(3); a_y = OW'(5);
    cycle();
    a_valid = 1'b0;
    repeat (6) cycle();
    chk("single_done", 64'(popped), 64'(1));

    // Contention: both requesters valid every cycle.
    a_valid = 1'b1; b_valid = 1'b1;
    repeat (12) begin rand_ops(); cycle(); end
    drain();

    // Backpressure: A streams while results are held.
    r_ready = 1'b0; a_valid = 1'b1; hs_a = 0;
    repeat (14) begin rand_ops(); cycle(); end
    chk("bp_accepted", 64'(hs_a), 64'(DEPTH));
    a_valid = 1'b0; r_ready = 1'b1;
    drain();

    // Wrap-around: 20 ops with r_ready toggling.
    start = acc;
    for (int c = 0; c < 300 && acc - start < 20; c++) begin
      rand_ops();
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      r_ready = (c % 2 == 0);
      cycle();
    end
    chk("wrap_count", 64'(acc - start >= 20), 64'(1));
    drain();

    // Reset mid-flight: 3 in flight, 2 in the FIFO.
    r_ready = 1'b0; a_valid = 1'b1;
    repeat (5) begin rand_ops(); cycle(); end
    a_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_r_valid", 64'(r_valid), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_mul_x", 64'(mul_x), 64'(0));
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
    r_ready = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    repeat (4) begin rand_ops(); cycle(); end
    drain();

    // Only B requesting.
    b_valid = 1'b1;
    repeat (6) begin rand_ops(); cycle(); end
    b_valid = 1'b0;
    repeat (2) cycle();
    drain();

    // Random traffic.
    for (int c = 0; c < 200; c++) begin
      rand_ops();
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      r_ready = ($urandom_range(3) != 0);
      cycle();
    end
    drain();
    chk("final_busy", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
